// File: rtl/vending_machine_param_pkg.sv
// Shared types for the parametrised vending controller: FSM states, coin codes, coin values.
package vending_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, REFUND} state_t;
  typedef enum logic [1:0] {COIN_NONE, COIN_5, COIN_10, COIN_20} coin_t;

  localparam int CHANGE_UNIT = 5;

  function automatic int unsigned coin_value(input coin_t c);
    case (c)
      COIN_5:  return 5;
      COIN_10: return 10;
      COIN_20: return 20;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_param.sv
// Coin-accumulating vending FSM with cancel/refund and Rs5 change pulses; all outputs registered.
// Coin at cycle t shows in CREDIT at t+1; no backpressure -- coins arriving while BUSY are rejected.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 40,
  parameter int CREDIT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          COIN,
  input  logic                CANCEL,
  output logic                OPEN,
  output logic                CHANGE,
  output logic                COIN_REJECT,
  output logic                BUSY,
  output logic [CREDIT_W-1:0] CREDIT
);

  localparam int W1 = CREDIT_W + 1;

  localparam logic [W1-1:0]       PRICE_X = W1'(PRICE);
  localparam logic [W1-1:0]       MAX_X   = W1'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);

  state_t              state;
  state_t              state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                reject_nxt;
  logic                coin_in;
  logic [W1-1:0]       sum;
  logic [CREDIT_W-1:0] remain;

  // One extra bit on the sum so an over-limit coin is caught before any wrap.
  assign coin_in = (COIN != 2'b00);
  assign sum     = {1'b0, CREDIT} + W1'(coin_value(coin_t'(COIN)));
  assign remain  = CREDIT - PRICE_C;

  always_comb begin
    state_nxt  = state;
    credit_nxt = CREDIT;
    reject_nxt = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (CANCEL) begin
          reject_nxt = coin_in;
          if (state == ACCUM) state_nxt = REFUND;
        end else if (coin_in) begin
          if (sum <= MAX_X) begin
            credit_nxt = sum[CREDIT_W-1:0];
            state_nxt  = (sum >= PRICE_X) ? VEND : ACCUM;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end
      VEND: begin
        reject_nxt = coin_in;
        credit_nxt = remain;
        state_nxt  = (remain != '0) ? REFUND : IDLE;
      end
      REFUND: begin
        reject_nxt = coin_in;
        credit_nxt = CREDIT - UNIT_C;
        state_nxt  = (CREDIT == UNIT_C) ? IDLE : REFUND;
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // Moore outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      CREDIT      <= '0;
      OPEN        <= 1'b0;
      CHANGE      <= 1'b0;
      COIN_REJECT <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_nxt;
      CREDIT      <= credit_nxt;
      OPEN        <= (state_nxt == VEND);
      CHANGE      <= (state_nxt == REFUND);
      COIN_REJECT <= reject_nxt;
      BUSY        <= (state_nxt == VEND) || (state_nxt == REFUND);
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor pops and compares them.
module tb_vending_machine_param;

  typedef struct packed {
    logic [31:0] cyc;
    logic        open;
    logic        change;
    logic        rej;
    logic        busy;
    logic [5:0]  credit;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, cancel_a, open_a, change_a, rej_a, busy_a;
  logic [1:0] coin_a;
  logic [5:0] credit_a;
  logic       rst_b, cancel_b, open_b, change_b, rej_b, busy_b;
  logic [1:0] coin_b;
  logic [5:0] credit_b;

  vending_machine_param u_dut_a (
    .clk(clk), .reset(rst_a), .COIN(coin_a), .CANCEL(cancel_a),
    .OPEN(open_a), .CHANGE(change_a), .COIN_REJECT(rej_a), .BUSY(busy_a), .CREDIT(credit_a)
  );

  vending_machine_param #(.PRICE(40), .MAX_CREDIT(40), .CREDIT_W(6)) u_dut_b (
    .clk(clk), .reset(rst_b), .COIN(coin_b), .CANCEL(cancel_b),
    .OPEN(open_b), .CHANGE(change_b), .COIN_REJECT(rej_b), .BUSY(busy_b), .CREDIT(credit_b)
  );

  ev_t  q_a[$];
  ev_t  q_b[$];
  int   total = 0;
  int   bad = 0;
  logic fin = 1'b0;
  logic [5:0] prev_a = '0;
  logic [5:0] prev_b = '0;

  task automatic cmp(input string tag, input ev_t g, input ev_t e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got cyc=%0d open=%0b change=%0b rej=%0b busy=%0b credit=%0d, expected cyc=%0d open=%0b change=%0b rej=%0b busy=%0b credit=%0d",
               tag, g.cyc, g.open, g.change, g.rej, g.busy, g.credit,
               e.cyc, e.open, e.change, e.rej, e.busy, e.credit);
    end
  endtask

  // Single checking process: reset check, event scoreboard for both DUTs, end-of-run drain check.
  always @(negedge clk) begin
    ev_t g;
    if (cyc == 3) begin
      g = '{cyc: 32'(cyc), open: open_a, change: change_a, rej: rej_a, busy: busy_a, credit: credit_a};
      cmp("reset_a", g, '{cyc: 32'(3), open: 1'b0, change: 1'b0, rej: 1'b0, busy: 1'b0, credit: 6'd0});
      g = '{cyc: 32'(cyc), open: open_b, change: change_b, rej: rej_b, busy: busy_b, credit: credit_b};
      cmp("reset_b", g, '{cyc: 32'(3), open: 1'b0, change: 1'b0, rej: 1'b0, busy: 1'b0, credit: 6'd0});
    end
    if (cyc > 4 && (open_a || change_a || rej_a || credit_a != prev_a)) begin
      g = '{cyc: 32'(cyc), open: open_a, change: change_a, rej: rej_a, busy: busy_a, credit: credit_a};
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_a: cyc=%0d open=%0b change=%0b rej=%0b credit=%0d, expected no event",
                 cyc, open_a, change_a, rej_a, credit_a);
      end else cmp("event_a", g, q_a.pop_front());
    end
    if (cyc > 4 && (open_b || change_b || rej_b || credit_b != prev_b)) begin
      g = '{cyc: 32'(cyc), open: open_b, change: change_b, rej: rej_b, busy: busy_b, credit: credit_b};
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_b: cyc=%0d open=%0b change=%0b rej=%0b credit=%0d, expected no event",
                 cyc, open_b, change_b, rej_b, credit_b);
      end else cmp("event_b", g, q_b.pop_front());
    end
    prev_a <= credit_a;
    prev_b <= credit_b;
    if (fin) begin
      total++;
      if (q_a.size() + q_b.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d events still pending, expected 0", q_a.size() + q_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic push_a(input int c, input logic o, input logic ch, input logic r, input logic b, input int cr);
    q_a.push_back('{cyc: 32'(c), open: o, change: ch, rej: r, busy: b, credit: 6'(cr)});
  endtask

  task automatic push_b(input int c, input logic o, input logic ch, input logic r, input logic b, input int cr);
    q_b.push_back('{cyc: 32'(c), open: o, change: ch, rej: r, busy: b, credit: 6'(cr)});
  endtask

  task automatic step_a(input logic [1:0] c, input logic k);
    @(negedge clk);
    coin_a = c; cancel_a = k;
  endtask

  task automatic step_b(input logic [1:0] c, input logic k);
    @(negedge clk);
    coin_b = c; cancel_b = k;
  endtask

  task automatic idle(input int n);
    repeat (n) step_a(2'b00, 1'b0);
  endtask

  initial begin
    int t;
    rst_a = 1'b1; rst_b = 1'b1;
    coin_a = 2'b00; cancel_a = 1'b0;
    coin_b = 2'b00; cancel_b = 1'b0;
    repeat (4) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    idle(2);

    // Exact pay: Rs5 then Rs10
    t = cyc + 1;
    push_a(t+1, 0, 0, 0, 0, 5); push_a(t+2, 1, 0, 0, 1, 15); push_a(t+3, 0, 0, 0, 0, 0);
    step_a(2'b01, 0); step_a(2'b10, 0); idle(5);

    // Overpay with Rs20; CANCEL during VEND is ignored
    t = cyc + 1;
    push_a(t+1, 1, 0, 0, 1, 20); push_a(t+2, 0, 1, 0, 1, 5); push_a(t+3, 0, 0, 0, 0, 0);
    step_a(2'b11, 0); step_a(2'b00, 1); idle(5);

    // Cancel after Rs5 + Rs5: two change pulses
    t = cyc + 1;
    push_a(t+1, 0, 0, 0, 0, 5); push_a(t+2, 0, 0, 0, 0, 10);
    push_a(t+3, 0, 1, 0, 1, 10); push_a(t+4, 0, 1, 0, 1, 5); push_a(t+5, 0, 0, 0, 0, 0);
    step_a(2'b01, 0); step_a(2'b01, 0); step_a(2'b00, 1); idle(6);

    // Rs10 during REFUND is rejected
    t = cyc + 1;
    push_a(t+1, 0, 0, 0, 0, 5); push_a(t+2, 0, 0, 0, 0, 10);
    push_a(t+3, 0, 1, 0, 1, 10); push_a(t+4, 0, 1, 1, 1, 5); push_a(t+5, 0, 0, 0, 0, 0);
    step_a(2'b01, 0); step_a(2'b01, 0); step_a(2'b00, 1); step_a(2'b10, 0); idle(5);

    // Rs5 together with CANCEL in ACCUM: cancel wins, coin rejected
    t = cyc + 1;
    push_a(t+1, 0, 0, 0, 0, 5); push_a(t+2, 0, 1, 1, 1, 5); push_a(t+3, 0, 0, 0, 0, 0);
    step_a(2'b01, 0); step_a(2'b01, 1); idle(5);

    // Coin during VEND is rejected
    t = cyc + 1;
    push_a(t+1, 1, 0, 0, 1, 20); push_a(t+2, 0, 1, 1, 1, 5); push_a(t+3, 0, 0, 0, 0, 0);
    step_a(2'b11, 0); step_a(2'b01, 0); idle(5);

    // CANCEL alone in IDLE does nothing; coin with CANCEL in IDLE is rejected
    t = cyc + 1;
    push_a(t+2, 0, 0, 1, 0, 0);
    step_a(2'b00, 1); step_a(2'b10, 1); idle(5);

    // Reset in the cycle after OPEN with Rs15 remaining abandons it
    t = cyc + 1;
    push_a(t+1, 0, 0, 0, 0, 10); push_a(t+2, 1, 0, 0, 1, 30);
    push_a(t+3, 0, 1, 0, 1, 15); push_a(t+4, 0, 0, 0, 0, 0);
    step_a(2'b10, 0); step_a(2'b11, 0); step_a(2'b00, 0);
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    idle(6);

    // Over-limit on the PRICE=40 instance: third coin rejected, Rs10 completes
    t = cyc + 1;
    push_b(t+1, 0, 0, 0, 0, 20); push_b(t+2, 0, 0, 0, 0, 30);
    push_b(t+3, 0, 0, 1, 0, 30); push_b(t+4, 1, 0, 0, 1, 40); push_b(t+5, 0, 0, 0, 0, 0);
    step_b(2'b11, 0); step_b(2'b10, 0); step_b(2'b11, 0); step_b(2'b10, 0); step_b(2'b00, 0);
    idle(6);

    fin = 1'b1;
    repeat (10) @(negedge clk);
    $display("FAIL watchdog: got no summary within 10 cycles, expected one");
    $fatal(1);
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor to the fixed-price Rs15 cola vending FSM.
- Price, credit ceiling and credit width are parameters.
- Adds a Rs20 coin, a customer CANCEL/refund path, over-limit coin rejection and multi-unit change return.
- Change is returned as a train of one-cycle CHANGE pulses, one per Rs5.
- Sits between the coin acceptor front-end and the dispense/change actuators; all outputs are Moore or registered.

Parameters:
PRICE, 15, product price in rupees; multiple of 5, 5 <= PRICE <= MAX_CREDIT
MAX_CREDIT, 40, highest credit the accumulator may hold; multiple of 5, < 2**CREDIT_W
CREDIT_W, 6, width of credit register and CREDIT output

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
COIN  input  2  coin inserted this cycle: 00=none, 01=Rs5, 10=Rs10, 11=Rs20
CANCEL  input  1  customer cancel request, level sampled each cycle
OPEN  output  1  high exactly one cycle per vend, releases can
CHANGE  output  1  high one cycle per Rs5 returned
COIN_REJECT  output  1  high one cycle after a coin was not accepted (coin routed to return chute)
BUSY  output  1  high while in VEND or REFUND
CREDIT  output  CREDIT_W  current credit in rupees (registered)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it has priority over all inputs.
- On reset:
  - state=IDLE, CREDIT=0.
  - OPEN=0, CHANGE=0, COIN_REJECT=0, BUSY=0.
  - Reset mid-VEND or mid-REFUND abandons the remaining credit; no further pulses.
- States: IDLE (credit 0), ACCUM (0 < credit < PRICE), VEND, REFUND.
- Moore outputs: OPEN = (state==VEND); CHANGE = (state==REFUND); BUSY = VEND|REFUND.
- Coin acceptance (IDLE/ACCUM only):
  - Let v = value(COIN).
  - If COIN != 00, CANCEL=0 and credit+v <= MAX_CREDIT: credit <= credit+v at the edge.
  - Next state: VEND if the new credit >= PRICE, else ACCUM.
- Coin rejection:
  - Cases: coin with credit+v > MAX_CREDIT; coin during VEND or REFUND; coin in the same cycle as CANCEL.
  - Effect: credit unchanged, COIN_REJECT=1 for the following cycle.
  - COIN=00 never sets COIN_REJECT.
- CANCEL:
  - In ACCUM: go to REFUND with credit unchanged; OPEN is never asserted.
  - In IDLE, VEND or REFUND: ignored.
  - CANCEL has priority over a simultaneous coin.
- VEND: lasts exactly one cycle. At exit, credit <= credit-PRICE; next state is REFUND if the remainder > 0, else IDLE.
- REFUND:
  - Each cycle: CHANGE=1 and credit <= credit-5.
  - When credit==5, next state is IDLE (credit becomes 0).
  - Number of CHANGE pulses = remainder/5.
- Latencies:
  - Coin sampled in cycle t reaches CREDIT in cycle t+1.
  - A completing coin at t gives OPEN at t+1, then the first CHANGE at t+2.
- Width: arithmetic is done at CREDIT_W+1 bits before the MAX_CREDIT compare, so the accumulator never wraps.
- Illegal state encoding: next state is IDLE with credit cleared.

Decomposition:
- Package vending_pkg holds:
  - state_t enum (IDLE, ACCUM, VEND, REFUND; 2-bit)
  - coin_t enum (COIN_NONE, COIN_5, COIN_10, COIN_20)
  - localparam CHANGE_UNIT=5
  - function coin_value(coin_t) returning the rupee value
- Single module; a sub-module is not warranted.
- Optional helper if the refund counter is reused elsewhere: vend_change_counter, a loadable down-counter that pulses per unit.

Test Plan:
- Exact pay, PRICE=15: Rs5 at t0, Rs10 at t1. Required: CREDIT=5 at t1, 15 at t2; OPEN=1 at t2 only; CHANGE never asserted; IDLE at t3.
- Overpay: Rs20 at t0. Required: OPEN at t1; CHANGE at t2 (one pulse); CREDIT=0 and IDLE at t3.
- Cancel: Rs5, Rs5, then CANCEL. Required: no OPEN; two CHANGE pulses on consecutive cycles; CREDIT 10 -> 5 -> 0.
- Over-limit, PRICE=40, MAX_CREDIT=40: Rs20, Rs10, Rs20. Required: third coin rejected, COIN_REJECT=1 for one cycle, CREDIT stays 30; a following Rs10 gives OPEN.
- Busy/simultaneous: Rs10 during REFUND, and Rs5 together with CANCEL in ACCUM. Required: both coins rejected, COIN_REJECT pulses, credit unaffected.
- Reset: assert reset in the cycle after OPEN with 15 remaining. Required: next cycle CHANGE=0, CREDIT=0, IDLE; no further pulses.
